// File: rtl/rv32_pkg.sv
// Shared RV32I constants and the EX/MEM pipeline register payload.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic            valid;
    logic            load;
    logic            store;
    logic            reg_write;
    logic            next_sel;
    logic            branch_result;
    logic [1:0]      mem_to_reg;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pre_address;
    logic [XLEN-1:0] instruction;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU; unused op codes yield zero.
module alu
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;

  always_comb begin
    y     = '0;
    shamt = b[4:0];
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = XLEN'($signed(a) >>> shamt);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, load-use detection and EX/MEM register.
module execute_stage
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            load_in,
  input  logic            store_in,
  input  logic            next_sel_in,
  input  logic            branch_result_in,
  input  logic            reg_write_in,
  input  logic [1:0]      mem_to_reg_in,
  input  logic [3:0]      alu_control_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [XLEN-1:0] opa_in,
  input  logic [XLEN-1:0] opb_in,
  input  logic [XLEN-1:0] opb_data_in,
  input  logic [XLEN-1:0] pre_address_in,
  input  logic [XLEN-1:0] instruction_in,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            stall_req,
  output logic            ex_valid,
  output logic            ex_load,
  output logic            ex_store,
  output logic            ex_reg_write,
  output logic            ex_next_sel,
  output logic            ex_branch_result,
  output logic [1:0]      ex_mem_to_reg,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_alu_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pre_address,
  output logic [XLEN-1:0] ex_instruction
);

  ex_mem_t         ex_q, ex_d, cap;
  logic [6:0]      opcode;
  logic            use_rs1, use_rs2_opb, use_rs2;
  logic            ex_fwd_ok, load_use;
  logic [XLEN-1:0] alu_a, alu_b, store_val, alu_y;

  // EX/MEM beats MEM/WB; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      r,
    input logic [XLEN-1:0] v,
    input logic            ex_ok,
    input logic [4:0]      ex_r,
    input logic [XLEN-1:0] ex_v,
    input logic            wb_ok,
    input logic [4:0]      wb_r,
    input logic [XLEN-1:0] wb_v
  );
    if (r == 5'd0)                  return v;
    else if (ex_ok && ex_r == r)    return ex_v;
    else if (wb_ok && wb_r == r)    return wb_v;
    else                            return v;
  endfunction

  always_comb begin
    opcode      = instruction_in[6:0];
    use_rs1     = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    use_rs2_opb = (opcode == OPC_OP);
    use_rs2     = use_rs2_opb || (opcode == OPC_STORE);
    ex_fwd_ok   = ex_q.valid && ex_q.reg_write && !ex_q.load;

    alu_a     = use_rs1 ? fwd(rs1_in, opa_in, ex_fwd_ok, ex_q.rd, ex_q.alu_result,
                              wb_reg_write, wb_rd, wb_data) : opa_in;
    alu_b     = use_rs2_opb ? fwd(rs2_in, opb_in, ex_fwd_ok, ex_q.rd, ex_q.alu_result,
                                  wb_reg_write, wb_rd, wb_data) : opb_in;
    store_val = fwd(rs2_in, opb_data_in, ex_fwd_ok, ex_q.rd, ex_q.alu_result,
                    wb_reg_write, wb_rd, wb_data);

    load_use  = ex_q.valid && ex_q.load && (ex_q.rd != 5'd0) &&
                ((use_rs1 && ex_q.rd == rs1_in) || (use_rs2 && ex_q.rd == rs2_in));
    stall_req = valid_in && load_use && !mem_stall;
  end

  alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_control_in),
    .y  (alu_y)
  );

  // Next EX/MEM contents: hold on mem_stall, else capture with kill on flush/bubble.
  always_comb begin
    cap.valid         = valid_in;
    cap.load          = load_in;
    cap.store         = store_in;
    cap.reg_write     = reg_write_in;
    cap.next_sel      = next_sel_in;
    cap.branch_result = branch_result_in;
    cap.mem_to_reg    = mem_to_reg_in;
    cap.rd            = instruction_in[11:7];
    cap.alu_result    = alu_y;
    cap.store_data    = store_val;
    cap.pre_address   = pre_address_in;
    cap.instruction   = instruction_in;
    if (flush || stall_req || !valid_in) begin
      cap.valid     = 1'b0;
      cap.load      = 1'b0;
      cap.store     = 1'b0;
      cap.reg_write = 1'b0;
    end
    ex_d = mem_stall ? ex_q : cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid         = ex_q.valid;
  assign ex_load          = ex_q.load;
  assign ex_store         = ex_q.store;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_next_sel      = ex_q.next_sel;
  assign ex_branch_result = ex_q.branch_result;
  assign ex_mem_to_reg    = ex_q.mem_to_reg;
  assign ex_rd            = ex_q.rd;
  assign ex_alu_result    = ex_q.alu_result;
  assign ex_store_data    = ex_q.store_data;
  assign ex_pre_address   = ex_q.pre_address;
  assign ex_instruction   = ex_q.instruction;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, load_in, store_in, next_sel_in, branch_result_in, reg_write_in;
  logic [1:0]  mem_to_reg_in;
  logic [3:0]  alu_control_in;
  logic [4:0]  rs1_in, rs2_in;
  logic [31:0] opa_in, opb_in, opb_data_in, pre_address_in, instruction_in;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_stall, flush;
  logic        stall_req, ex_valid, ex_load, ex_store, ex_reg_write, ex_next_sel, ex_branch_result;
  logic [1:0]  ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data, ex_pre_address, ex_instruction;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] AUIPC = 7'b0010111;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .load_in(load_in), .store_in(store_in),
    .next_sel_in(next_sel_in), .branch_result_in(branch_result_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .alu_control_in(alu_control_in), .rs1_in(rs1_in),
    .rs2_in(rs2_in), .opa_in(opa_in), .opb_in(opb_in), .opb_data_in(opb_data_in),
    .pre_address_in(pre_address_in), .instruction_in(instruction_in),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .mem_stall(mem_stall),
    .flush(flush), .stall_req(stall_req), .ex_valid(ex_valid), .ex_load(ex_load),
    .ex_store(ex_store), .ex_reg_write(ex_reg_write), .ex_next_sel(ex_next_sel),
    .ex_branch_result(ex_branch_result), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_pre_address(ex_pre_address), .ex_instruction(ex_instruction)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] opc, input logic [4:0] rd, input logic [3:0] alu,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    valid_in       = 1'b1;
    load_in        = (opc == LOAD);
    store_in       = (opc == STORE);
    reg_write_in   = (opc != STORE);
    next_sel_in    = 1'b0;
    branch_result_in = 1'b0;
    mem_to_reg_in  = (opc == LOAD) ? 2'd1 : 2'd0;
    alu_control_in = alu;
    rs1_in         = r1;
    rs2_in         = r2;
    opa_in         = a;
    opb_in         = b;
    opb_data_in    = sd;
    instruction_in = {20'h0, rd, opc};
    pre_address_in = pre_address_in + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 0; load_in = 0; store_in = 0; next_sel_in = 0;
    branch_result_in = 0; reg_write_in = 0; mem_to_reg_in = 0; alu_control_in = 0;
    rs1_in = 0; rs2_in = 0; opa_in = 0; opb_in = 0; opb_data_in = 0;
    pre_address_in = 32'h1000; instruction_in = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0; mem_stall = 0; flush = 0;
    #12;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_alu", ex_alu_result, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    rst_n = 1'b1;

    // ADD x1 = 5+7, then ADD x2 = x1+x1 back-to-back
    tick();
    instr(OP, 5'd1, 4'd0, 5'd10, 5'd11, 32'd5, 32'd7, 32'd0);
    tick();
    check("add1_res", ex_alu_result, 32'd12);
    check("add1_rd", 32'(ex_rd), 32'd1);
    check("add1_pc", ex_pre_address, 32'h1004);
    instr(OP, 5'd2, 4'd0, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0);
    #1 check("add2_nostall", 32'(stall_req), 32'd0);
    tick();
    check("add2_fwd", ex_alu_result, 32'd24);
    check("add2_valid", 32'(ex_valid), 32'd1);

    // LW x3, then dependent ADD x4 = x3 + x0
    instr(LOAD, 5'd3, 4'd0, 5'd0, 5'd0, 32'h100, 32'd0, 32'd0);
    tick();
    check("lw_load", 32'(ex_load), 32'd1);
    instr(OP, 5'd4, 4'd0, 5'd3, 5'd0, 32'd0, 32'd0, 32'd0);
    #1 check("lu_stall", 32'(stall_req), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    #1 check("lu_stall_once", 32'(stall_req), 32'd0);
    tick();
    check("lu_wb_fwd", ex_alu_result, 32'h55);
    check("lu_wb_valid", 32'(ex_valid), 32'd1);

    // x5 in EX/MEM (9) and MEM/WB (3): EX/MEM wins
    wb_reg_write = 1'b0;
    instr(OP, 5'd5, 4'd0, 5'd0, 5'd0, 32'd4, 32'd5, 32'd0);
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'd3;
    instr(OP, 5'd6, 4'd0, 5'd5, 5'd0, 32'h77, 32'd0, 32'd0);
    tick();
    check("prio_ex", ex_alu_result, 32'd9);

    // rd=0 writer in EX and wb_rd=0: no forwarding
    wb_reg_write = 1'b0;
    instr(OP, 5'd0, 4'd0, 5'd0, 5'd0, 32'd1, 32'd2, 32'd0);
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hdead;
    instr(OP, 5'd7, 4'd0, 5'd0, 5'd0, 32'h40, 32'd1, 32'd0);
    tick();
    check("x0_nofwd", ex_alu_result, 32'h41);
    wb_reg_write = 1'b0;

    // SW with store data forwarded from x7 in EX/MEM
    instr(STORE, 5'd0, 4'd0, 5'd0, 5'd7, 32'h200, 32'd8, 32'd0);
    tick();
    check("sw_addr", ex_alu_result, 32'h208);
    check("sw_data", ex_store_data, 32'h41);
    check("sw_store", 32'(ex_store), 32'd1);

    // AUIPC ignores rs1 field even if it matches a pending writer
    instr(OP, 5'd14, 4'd0, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0);
    tick();
    instr(AUIPC, 5'd15, 4'd0, 5'd14, 5'd0, 32'h1000, 32'h2000, 32'd0);
    tick();
    check("auipc_nofwd", ex_alu_result, 32'h3000);

    // flush kills the instruction entering EX/MEM
    instr(OP, 5'd8, 4'd0, 5'd0, 5'd0, 32'd2, 32'd2, 32'd0);
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_rw", 32'(ex_reg_write), 32'd0);
    flush = 1'b0;

    // mem_stall holds EX/MEM for 3 cycles, flush ignored meanwhile
    instr(OP, 5'd9, 4'd0, 5'd0, 5'd0, 32'h10, 32'h20, 32'd0);
    tick();
    instr(OP, 5'd10, 4'd0, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0);
    mem_stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ms_res", ex_alu_result, 32'h30);
      check("ms_valid", 32'(ex_valid), 32'd1);
      check("ms_rd", 32'(ex_rd), 32'd9);
    end
    mem_stall = 1'b0; flush = 1'b0;
    tick();
    check("ms_release", ex_alu_result, 32'd2);
    check("ms_release_rd", 32'(ex_rd), 32'd10);

    // ALU corner cases
    instr(OP, 5'd1, 4'd7, 5'd0, 5'd0, 32'h80000000, 32'd31, 32'd0);
    tick();
    check("sra", ex_alu_result, 32'hFFFFFFFF);
    instr(OP, 5'd1, 4'd4, 5'd0, 5'd0, 32'd1, 32'hFFFFFFFF, 32'd0);
    tick();
    check("sltu", ex_alu_result, 32'd1);
    instr(OP, 5'd1, 4'd3, 5'd0, 5'd0, 32'd1, 32'hFFFFFFFF, 32'd0);
    tick();
    check("slt", ex_alu_result, 32'd0);
    instr(OP, 5'd1, 4'd1, 5'd0, 5'd0, 32'd0, 32'd1, 32'd0);
    tick();
    check("sub_wrap", ex_alu_result, 32'hFFFFFFFF);
    instr(OP, 5'd1, 4'd13, 5'd0, 5'd0, 32'd5, 32'd6, 32'd0);
    tick();
    check("op13", ex_alu_result, 32'd0);

    // load-use under mem_stall: no stall_req; then reset mid-stall
    instr(LOAD, 5'd11, 4'd0, 5'd0, 5'd0, 32'h300, 32'd0, 32'd0);
    tick();
    instr(OP, 5'd12, 4'd0, 5'd11, 5'd0, 32'd0, 32'd0, 32'd0);
    mem_stall = 1'b1;
    #1 check("lu_ms_nostall", 32'(stall_req), 32'd0);
    tick();
    check("lu_ms_hold", 32'(ex_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_load", 32'(ex_load), 32'd0);
    check("arst_alu", ex_alu_result, 32'd0);
    check("arst_rd", 32'(ex_rd), 32'd0);
    check("arst_instr", ex_instruction, 32'd0);
    check("arst_stall", 32'(stall_req), 32'd0);
    mem_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    instr(OP, 5'd13, 4'd0, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0);
    tick();
    check("post_rst_res", ex_alu_result, 32'd7);
    check("post_rst_valid", 32'(ex_valid), 32'd1);
    check("post_rst_rd", 32'(ex_rd), 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
